// File: rtl/modulo_pkg.sv
// Shared types and helpers for the bit-serial modulo checker.
// State encoding and the remainder-width constant function.
package modulo_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // MODULUS==2 still needs one bit even though $clog2 handles it; kept explicit for clarity.
  function automatic int unsigned rem_width(input int unsigned modulus);
    return (modulus == 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/mod_step.sv
// One remainder step: next = (2*rem + bit) mod MODULUS using a single conditional subtract.
module mod_step
  import modulo_pkg::*;
#(
  parameter int unsigned MODULUS = 3,
  localparam int unsigned REM_W = rem_width(MODULUS)
) (
  input  logic [REM_W-1:0] i_rem,
  input  logic             i_bit,
  output logic [REM_W-1:0] o_rem
);

  localparam logic [REM_W:0] MOD_V = (REM_W + 1)'(MODULUS);

  logic [REM_W:0] w_sum;
  logic [REM_W:0] w_diff;

  // rem < MODULUS, so 2*rem+bit < 2*MODULUS and one subtract always suffices.
  always_comb begin
    w_sum  = {i_rem, i_bit};
    w_diff = w_sum - MOD_V;
    if (w_sum >= MOD_V) begin
      o_rem = w_diff[REM_W-1:0];
    end else begin
      o_rem = w_sum[REM_W-1:0];
    end
  end

endmodule

// File: rtl/modulo_n_serial.sv
// Bit-serial divisibility checker: streams a word MSB-first and reports word mod MODULUS.
// Optional feature MODN_COUNT_EN adds a saturating count of divisible results (div_count).
module modulo_n_serial
  import modulo_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 3,
  localparam int unsigned REM_W  = rem_width(MODULUS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REM_W-1:0] remainder,
`ifdef MODN_COUNT_EN
  output logic [15:0]      div_count,
`endif
  output logic             divisible
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [REM_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [REM_W-1:0] r_remainder;
  logic             r_divisible;
  logic [REM_W-1:0] w_rem_next;

  mod_step #(
    .MODULUS (MODULUS)
  ) u_mod_step (
    .i_rem (r_rem),
    .i_bit (r_shreg[WIDTH-1]),
    .o_rem (w_rem_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_shreg     <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_remainder <= '0;
      r_divisible <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_shreg    <= in_data;
            r_rem      <= '0;
            r_cnt      <= CNT_MAX;
            r_in_ready <= 1'b0;
            r_state    <= StBusy;
          end
        end
        StBusy: begin
          r_shreg <= r_shreg << 1;
          r_rem   <= w_rem_next;
          if (r_cnt == '0) begin
            // Result registers load on the same edge that consumes the last bit.
            r_out_valid <= 1'b1;
            r_remainder <= w_rem_next;
            r_divisible <= (w_rem_next == '0);
            r_state     <= StDone;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_divisible <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_divisible <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

`ifdef MODN_COUNT_EN
  logic [15:0] r_div_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_count <= '0;
    end else if (r_state == StDone && out_ready && r_divisible && r_div_count != 16'hFFFF) begin
      r_div_count <= r_div_count + 16'd1;
    end
  end

  assign div_count = r_div_count;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign remainder = r_remainder;
  assign divisible = r_divisible;

endmodule

// File: tb/tb_modulo_n_serial.sv
// Directed bench for modulo_n_serial: W=8/M=3 and W=12/M=5 instances.
// The div_count check runs only when MODN_COUNT_EN is defined.
module tb_modulo_n_serial;

  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_divisible;
  logic [7:0] a_in_data;
  logic [1:0] a_remainder;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_divisible;
  logic [11:0] b_in_data;
  logic [2:0]  b_remainder;

`ifdef MODN_COUNT_EN
  logic [15:0] a_div_count;
  logic [15:0] b_div_count;
`endif

  int checks;
  int failures;

  modulo_n_serial #(
    .WIDTH   (8),
    .MODULUS (3)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .remainder (a_remainder),
`ifdef MODN_COUNT_EN
    .div_count (a_div_count),
`endif
    .divisible (a_divisible)
  );

  modulo_n_serial #(
    .WIDTH   (12),
    .MODULUS (5)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .remainder (b_remainder),
`ifdef MODN_COUNT_EN
    .div_count (b_div_count),
`endif
    .divisible (b_divisible)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Latency counted including the accepting edge: out_valid is seen after WIDTH+1 edges.
  task automatic run_a(input logic [7:0] d, input int hold, input logic [1:0] exp_rem,
                       input logic exp_div);
    int n;
    n = 0;
    while (!a_in_ready && n < 50) begin
      step();
      n++;
    end
    check_eq("a_ready_wait", 32'(a_in_ready), 32'd1);
    a_in_data  = d;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    check_eq("a_busy_ready", 32'(a_in_ready), 32'd0);
    n = 1;
    while (!a_out_valid && n < 50) begin
      step();
      n++;
    end
    check_eq("a_latency", 32'(n), 32'd9);
    check_eq("a_rem", 32'(a_remainder), 32'(exp_rem));
    check_eq("a_div", 32'(a_divisible), 32'(exp_div));
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("a_hold_valid", 32'(a_out_valid), 32'd1);
      check_eq("a_hold_rem", 32'(a_remainder), 32'(exp_rem));
      check_eq("a_hold_ready", 32'(a_in_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    check_eq("a_valid_clr", 32'(a_out_valid), 32'd0);
    check_eq("a_div_clr", 32'(a_divisible), 32'd0);
    check_eq("a_rem_keep", 32'(a_remainder), 32'(exp_rem));
    check_eq("a_ready_back", 32'(a_in_ready), 32'd1);
  endtask

  task automatic run_b(input logic [11:0] d, input logic [2:0] exp_rem, input logic exp_div);
    int n;
    n = 0;
    while (!b_in_ready && n < 50) begin
      step();
      n++;
    end
    check_eq("b_ready_wait", 32'(b_in_ready), 32'd1);
    b_in_data  = d;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 50) begin
      step();
      n++;
    end
    check_eq("b_latency", 32'(n), 32'd13);
    check_eq("b_rem", 32'(b_remainder), 32'(exp_rem));
    check_eq("b_div", 32'(b_divisible), 32'(exp_div));
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    check_eq("b_valid_clr", 32'(b_out_valid), 32'd0);
  endtask

  initial begin
    int  n;
    logic seen;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    check_eq("rst_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_rem", 32'(a_remainder), 32'd0);
    check_eq("rst_div", 32'(a_divisible), 32'd0);
    check_eq("rst_ready", 32'(a_in_ready), 32'd1);
    check_eq("rst_b_ready", 32'(b_in_ready), 32'd1);

    run_a(8'd0, 0, 2'd0, 1'b1);
    run_a(8'd7, 0, 2'd1, 1'b0);
    run_a(8'd255, 0, 2'd0, 1'b1);
    run_a(8'd128, 5, 2'd2, 1'b0);

    run_b(12'd100, 3'd0, 1'b1);
    run_b(12'd4093, 3'd3, 1'b0);
    run_b(12'd4095, 3'd0, 1'b1);
    run_b(12'd2049, 3'd4, 1'b0);

    // Abort a word on the fourth cycle after acceptance.
    n = 0;
    while (!a_in_ready && n < 50) begin
      step();
      n++;
    end
    a_in_data  = 8'd200;
    a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen = seen | a_out_valid;
      step();
    end
    check_eq("abort_no_valid", 32'(seen), 32'd0);
    check_eq("abort_ready", 32'(a_in_ready), 32'd1);
    check_eq("abort_rem", 32'(a_remainder), 32'd0);

    run_a(8'd6, 0, 2'd0, 1'b1);
    run_a(8'd7, 0, 2'd1, 1'b0);
    run_a(8'd45, 0, 2'd0, 1'b1);
    run_a(8'd96, 0, 2'd0, 1'b1);
    run_a(8'd100, 0, 2'd1, 1'b0);
`ifdef MODN_COUNT_EN
    check_eq("div_count", 32'(a_div_count), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
